// File: rtl/sl_pkg.sv
// Shared SL definitions: state encoding, rate-to-period table and line levels.
// Used by both the SL transmit serializer and the SL receiver.
package sl_pkg;

   localparam int   MIN_LEN = 8;       // shortest legal word length
   localparam int   PHASE_W = 7;       // phase counter width, covers P-1 up to 127
   localparam logic SL_IDLE = 1'b1;    // idle / gap level of both SL wires

   // One-hot frame states
   typedef enum logic [3:0] {
      ST_IDLE   = 4'b0001,
      ST_DATA   = 4'b0010,
      ST_PARITY = 4'b0100,
      ST_STOP   = 4'b1000
   } sl_state_e;

   // Bit-period select codes: P = 16 << rate
   typedef enum logic [1:0] {
      RATE_16  = 2'b00,
      RATE_32  = 2'b01,
      RATE_64  = 2'b10,
      RATE_128 = 2'b11
   } sl_rate_e;

   // Last phase value of a symbol (P-1)
   function automatic logic [PHASE_W-1:0] period_last(input logic [1:0] rate);
      logic [PHASE_W-1:0] last;
      unique case (sl_rate_e'(rate))
         RATE_16:  last = 7'd15;
         RATE_32:  last = 7'd31;
         RATE_64:  last = 7'd63;
         RATE_128: last = 7'd127;
         default:  last = 7'd15;
      endcase
      return last;
   endfunction

   // Last phase value of the low half of a symbol (P/2-1)
   function automatic logic [PHASE_W-1:0] half_last(input logic [1:0] rate);
      logic [PHASE_W-1:0] last;
      unique case (sl_rate_e'(rate))
         RATE_16:  last = 7'd7;
         RATE_32:  last = 7'd15;
         RATE_64:  last = 7'd31;
         RATE_128: last = 7'd63;
         default:  last = 7'd7;
      endcase
      return last;
   endfunction

endpackage

// File: rtl/sl_bit_timer.sv
// Symbol phase counter. Counts 0..P-1 while run_i is high and flags the end of
// the low half (half_tick_o) and the end of the whole symbol (sym_end_o).
module sl_bit_timer
   import sl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run_i,
   input  logic [1:0] rate_i,
   output logic       half_tick_o,
   output logic       sym_end_o
);

   logic [PHASE_W-1:0] phase_q, phase_d;

   assign sym_end_o   = run_i && (phase_q == period_last(rate_i));
   assign half_tick_o = run_i && (phase_q == half_last(rate_i));

   // Next phase: hold at zero when idle, wrap at the end of every symbol
   always_comb begin
      // NOTE: assign a default first so every path drives phase_d and no latch is inferred.
      phase_d = phase_q;
      if (!run_i || sym_end_o) begin
         phase_d = '0;
      end else begin
         phase_d = phase_q + 1'b1;
      end
   end

   // Phase register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= '0;
      end else begin
         // NOTE: non-blocking assignment so all flops update together on the edge.
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/sl_tx_serializer.sv
// SL transmit serializer: sends a latched word MSB first as SL0/SL1 low pulses,
// followed by an odd-parity symbol and a both-wires-low stop symbol.
module sl_tx_serializer
   import sl_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 6,
   parameter int MIN_LEN = sl_pkg::MIN_LEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [LEN_W-1:0]  tx_len,
   input  logic [1:0]        tx_rate,
   input  logic              tx_start,
   output logic              tx_busy,
   output logic              tx_done,
   output logic              tx_ovr,
   output logic              sl0_o,
   output logic              sl1_o,
   output logic              sl_oe
);

   sl_state_e         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;     // MSB is the bit currently on the wires
   logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d; // data bits remaining after the current one
   logic [1:0]        rate_q, rate_d;
   logic              par_q, par_d;         // running XOR of data bits already sent
   logic              gap_q, gap_d;         // high during the second half of a symbol
   logic              done_q, done_d;
   logic              ovr_q, ovr_d;

   logic              half_tick;
   logic              sym_end;
   logic              busy;
   logic              low_phase;
   logic [LEN_W-1:0]  len_clamped;

   assign busy      = (state_q != ST_IDLE);
   assign low_phase = busy && !gap_q;

   sl_bit_timer u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .run_i       (busy),
      .rate_i      (rate_q),
      .half_tick_o (half_tick),
      .sym_end_o   (sym_end)
   );

   // Clamp the requested length into MIN_LEN..DATA_W
   always_comb begin
      len_clamped = tx_len;
      if (tx_len < LEN_W'(MIN_LEN)) begin
         len_clamped = LEN_W'(MIN_LEN);
      end else if (tx_len > LEN_W'(DATA_W)) begin
         len_clamped = LEN_W'(DATA_W);
      end
   end

   // Frame FSM: next state, shift register, bit counter, parity and strobes
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      rate_d    = rate_q;
      par_d     = par_q;
      done_d    = 1'b0;
      // A start while busy, or on the tx_done cycle, is dropped and flagged
      ovr_d     = tx_start && (busy || done_q);

      unique case (state_q)
         ST_IDLE: begin
            if (tx_start && !done_q) begin
               state_d   = ST_DATA;
               // Left-align the word so bit[len-1] sits in the MSB
               shift_d   = tx_data << (LEN_W'(DATA_W) - len_clamped);
               bit_cnt_d = len_clamped - LEN_W'(1);
               rate_d    = tx_rate;
               par_d     = 1'b0;
            end
         end
         ST_DATA: begin
            if (sym_end) begin
               shift_d = shift_q << 1;
               par_d   = par_q ^ shift_q[DATA_W-1];
               if (bit_cnt_q == '0) begin
                  state_d = ST_PARITY;
               end else begin
                  bit_cnt_d = bit_cnt_q - LEN_W'(1);
               end
            end
         end
         ST_PARITY: begin
            if (sym_end) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (sym_end) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Gap flag: set at the end of the low half, cleared at symbol end or when idle
   always_comb begin
      gap_d = gap_q;
      if (!busy || sym_end) begin
         gap_d = 1'b0;
      end else if (half_tick) begin
         gap_d = 1'b1;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         rate_q    <= '0;
         par_q     <= 1'b0;
         gap_q     <= 1'b0;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         rate_q    <= rate_d;
         par_q     <= par_d;
         gap_q     <= gap_d;
         done_q    <= done_d;
         ovr_q     <= ovr_d;
      end
   end

   // Line drive: one wire low per symbol low half, both low in the stop low half
   always_comb begin
      sl0_o = SL_IDLE;
      sl1_o = SL_IDLE;
      if (low_phase) begin
         unique case (state_q)
            ST_DATA: begin
               if (shift_q[DATA_W-1]) sl1_o = ~SL_IDLE;
               else                   sl0_o = ~SL_IDLE;
            end
            ST_PARITY: begin
               // Parity bit is ~par_q so the total count of ones is odd
               if (!par_q) sl1_o = ~SL_IDLE;
               else        sl0_o = ~SL_IDLE;
            end
            ST_STOP: begin
               sl0_o = ~SL_IDLE;
               sl1_o = ~SL_IDLE;
            end
            default: ;
         endcase
      end
   end

   assign tx_busy = busy;
   assign sl_oe   = busy;
   assign tx_done = done_q;
   assign tx_ovr  = ovr_q;

endmodule

// File: tb/tb_sl_tx_serializer.sv
// Self-checking bench for sl_tx_serializer: table-driven frames plus reset,
// overrun and input-stability sequences.
`timescale 1ns/1ps
module tb_sl_tx_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] tx_data;
   logic [5:0]  tx_len;
   logic [1:0]  tx_rate;
   logic        tx_start;
   logic        tx_busy, tx_done, tx_ovr, sl0_o, sl1_o, sl_oe;

   int n_checks = 0;
   int n_fail   = 0;
   int chk_errs = 0;

   typedef struct {
      logic [31:0] data;
      logic [5:0]  len;
      logic [1:0]  rate;
      int          exp_len;     // effective (clamped) data length
      int          exp_p;       // bit period in clk
      bit          exp_par;     // parity symbol value
      int          exp_cycles;  // first pulse to end of stop gap
      bit          scramble;    // wiggle inputs during the frame
      int          ovr_k;       // frame cycle to pulse tx_start, -1 for none
      bit          done_start;  // pulse tx_start on the tx_done cycle
   } vec_t;

   vec_t vecs[8];

   sl_tx_serializer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_data  (tx_data),
      .tx_len   (tx_len),
      .tx_rate  (tx_rate),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .tx_ovr   (tx_ovr),
      .sl0_o    (sl0_o),
      .sl1_o    (sl1_o),
      .sl_oe    (sl_oe)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Background checker: sl_oe tracks tx_busy; both wires never low while idle
   always @(negedge clk) begin
      if (sl_oe !== tx_busy || (!tx_busy && !sl0_o && !sl1_o)) begin
         chk_errs++;
         if (chk_errs <= 5)
            $display("FAIL checker @%0t: sl_oe=%0b tx_busy=%0b sl0=%0b sl1=%0b",
                     $time, sl_oe, tx_busy, sl0_o, sl1_o);
      end
   end

   // Send one frame from the table and compare every cycle against the model
   task automatic do_frame(input vec_t v, input string name);
      int  errs, first_bad, ovr_seen, sym, ph;
      bit  low, b, e0, e1, e_ovr;
      errs = 0; first_bad = -1; ovr_seen = 0;
      tx_data = v.data; tx_len = v.len; tx_rate = v.rate; tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      for (int k = 0; k < v.exp_cycles; k++) begin
         sym = k / v.exp_p;
         ph  = k % v.exp_p;
         low = (ph < v.exp_p / 2);
         if (sym < v.exp_len) b = v.data[v.exp_len - 1 - sym];
         else                 b = v.exp_par;
         if (sym == v.exp_len + 1) begin
            e0 = !low; e1 = !low;
         end else begin
            e0 = !(low && !b);
            e1 = !(low && b);
         end
         e_ovr = (v.ovr_k >= 0) && (k == v.ovr_k + 1);
         ovr_seen += tx_ovr;
         if (sl0_o !== e0 || sl1_o !== e1 || tx_busy !== 1'b1 || sl_oe !== 1'b1 ||
             tx_done !== 1'b0 || tx_ovr !== e_ovr) begin
            errs++;
            if (first_bad < 0) first_bad = k;
         end
         tx_start = (k == v.ovr_k);
         if (v.scramble) begin
            tx_data = $urandom;
            tx_len  = 6'($urandom);
            tx_rate = 2'($urandom);
         end
         @(negedge clk);
      end
      if (errs != 0) $display("  %s first bad frame cycle %0d", name, first_bad);
      check({name, " waveform_errs"}, errs, 0);
      check({name, " ovr_pulses"}, ovr_seen, (v.ovr_k >= 0) ? 1 : 0);
      check({name, " done_pulse"}, tx_done, 1);
      check({name, " done_busy"}, tx_busy, 0);
      check({name, " done_lines"}, {sl0_o, sl1_o}, 2'b11);
      check({name, " done_ovr"}, tx_ovr, 0);
      tx_start = v.done_start;
      @(negedge clk);
      tx_start = 1'b0;
      check({name, " done_once"}, tx_done, 0);
      check({name, " post_ovr"}, tx_ovr, v.done_start);
      check({name, " post_busy"}, tx_busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit done_seen;
      //             data          len    rate len  P   par cycles scr ovr  dstart
      vecs[0] = '{32'h0000_00A5, 6'd8,  2'd0,  8, 16, 1,  160, 0,  -1, 0};
      vecs[1] = '{32'hFFFF_FFFF, 6'd32, 2'd3, 32,128, 1, 4352, 0,  -1, 0};
      vecs[2] = '{32'h0000_0001, 6'd3,  2'd0,  8, 16, 0,  160, 0,  -1, 0};
      vecs[3] = '{32'h8000_0001, 6'd40, 2'd1, 32, 32, 1, 1088, 0, 100, 1};
      vecs[4] = '{32'h0000_0F0F, 6'd12, 2'd2, 12, 64, 1,  896, 1,  -1, 0};
      vecs[5] = '{32'h0001_2345, 6'd17, 2'd0, 17, 16, 0,  304, 0,   5, 1};
      vecs[6] = '{32'hFFFF_FF00, 6'd0,  2'd0,  8, 16, 1,  160, 0,  -1, 0};
      vecs[7] = '{32'h0000_0000, 6'd63, 2'd0, 32, 16, 1,  544, 1, 200, 0};

      rst_n = 1'b0; tx_data = '0; tx_len = '0; tx_rate = '0; tx_start = 1'b0;
      repeat (3) @(negedge clk);
      check("reset sl0", sl0_o, 1);
      check("reset sl1", sl1_o, 1);
      check("reset oe", sl_oe, 0);
      check("reset busy", tx_busy, 0);
      check("reset done", tx_done, 0);
      check("reset ovr", tx_ovr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset in the middle of a frame
      tx_data = 32'h0000_00A5; tx_len = 6'd8; tx_rate = 2'd0; tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      check("midrst busy before", tx_busy, 1);
      repeat (40) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst sl0", sl0_o, 1);
      check("midrst sl1", sl1_o, 1);
      check("midrst oe", sl_oe, 0);
      check("midrst busy", tx_busy, 0);
      done_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         done_seen |= tx_done;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         done_seen |= tx_done;
      end
      check("midrst no_done", done_seen, 0);

      // Table frames; vecs[3]->vecs[4] and vecs[5]->vecs[6] are back-to-back
      for (int i = 0; i < 8; i++) begin
         do_frame(vecs[i], $sformatf("vec%0d", i));
      end

      check("checker violations", chk_errs, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
